// File: rtl/sqr_sum_accu_pkg.sv
// Shared types and helpers for the sum-of-squares energy accumulator.
package sqr_sum_accu_pkg;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

    // Overflow test for an unsigned w-bit add; operands must already fit in w bits (w <= 63).
    function automatic logic sat_add_ovf(input logic [63:0] a, input logic [63:0] b,
                                         input int unsigned w);
        logic [64:0] full;
        full = {1'b0, a} + {1'b0, b};
        return |(full >> w);
    endfunction

endpackage

// File: rtl/sqr_sum_accu_sqrsgn.sv
// Combinational signed squarer: |x|^2 as an unsigned 2*width result.
module SqrSgn #(
    parameter int width = 8,
    parameter int speed = 2
) (
    input  logic [width-1:0]   in_i,
    output logic [2*width-1:0] sq_o
);

    logic [width-1:0] w_mag;

    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign w_mag = in_i[width-1] ? (~in_i + width'(1)) : in_i;

    generate
        if (speed == 0) begin : g_shift_add
            logic [2*width-1:0] w_pp [width];
            logic [2*width-1:0] w_sum;
            for (genvar gi = 0; gi < width; gi++) begin : g_pp
                assign w_pp[gi] = w_mag[gi] ? ({{width{1'b0}}, w_mag} << gi) : '0;
            end
            always_comb begin
                w_sum = '0;
                for (int i = 0; i < width; i++) begin
                    w_sum = w_sum + w_pp[i];
                end
            end
            assign sq_o = w_sum;
        end else begin : g_mult
            assign sq_o = {{width{1'b0}}, w_mag} * {{width{1'b0}}, w_mag};
        end
    endgenerate

endmodule

// File: rtl/sqr_sum_accu.sv
// Streaming frame energy: squares each sample, accumulates over a frame, emits sum/count/sat.
module sqr_sum_accu
    import sqr_sum_accu_pkg::*;
#(
    parameter int width    = 8,
    parameter int speed    = 2,
    parameter int AccWidth = 2*width+8,
    parameter int CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [width-1:0]    in_data_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [AccWidth-1:0] out_sum_o,
    output logic [CntWidth-1:0] out_cnt_o,
    output logic                out_sat_o
);

    logic [width-1:0]    r_x;
    logic                r_last;
    logic                r_vld;
    state_e              r_state, w_state_next;
    logic [AccWidth-1:0] r_acc, w_acc_next, w_acc_sum;
    logic [CntWidth-1:0] r_cnt, w_cnt_next, w_cnt_sum;
    logic                r_sat, w_sat_next;
    logic                w_acc_ovf, w_cnt_ovf;
    logic [2*width-1:0]  w_sq;
    logic                w_in_fire, w_enter_out, w_leave_out;
    logic                r_out_valid;
    logic [AccWidth-1:0] r_out_sum;
    logic [CntWidth-1:0] r_out_cnt;
    logic                r_out_sat;

    SqrSgn #(.width(width), .speed(speed)) u_sqr (
        .in_i (r_x),
        .sq_o (w_sq)
    );

    // S0 only blocks while a finished result is waiting to be taken.
    assign in_ready_o = (r_state != OUT) | ~r_vld;
    assign w_in_fire  = in_valid_i & in_ready_o;

    assign w_acc_sum = r_acc + AccWidth'(w_sq);
    assign w_acc_ovf = sat_add_ovf(64'(r_acc), 64'(w_sq), AccWidth);
    assign w_cnt_sum = r_cnt + CntWidth'(1);
    assign w_cnt_ovf = &r_cnt;

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_sat_next   = r_sat;
        case (r_state)
            IDLE: begin
                if (r_vld) begin
                    w_acc_next   = AccWidth'(w_sq);
                    w_cnt_next   = CntWidth'(1);
                    w_sat_next   = 1'b0;
                    w_state_next = r_last ? OUT : ACC;
                end
            end
            ACC: begin
                if (r_vld) begin
                    w_acc_next = w_acc_ovf ? '1 : w_acc_sum;
                    w_cnt_next = w_cnt_ovf ? r_cnt : w_cnt_sum;
                    w_sat_next = r_sat | w_acc_ovf | w_cnt_ovf;
                    if (r_last) begin
                        w_state_next = OUT;
                    end
                end
            end
            OUT: begin
                if (out_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_enter_out = (r_state != OUT) && (w_state_next == OUT);
    assign w_leave_out = (r_state == OUT) && (w_state_next != OUT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_x         <= '0;
            r_last      <= 1'b0;
            r_vld       <= 1'b0;
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cnt   <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_x    <= in_data_i;
                r_last <= in_last_i;
                r_vld  <= 1'b1;
            end else if (r_state != OUT) begin
                r_vld  <= 1'b0;
            end
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_sat   <= w_sat_next;
            // Result registers carry data only while in OUT and read as zero otherwise.
            if (w_enter_out) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_acc_next;
                r_out_cnt   <= w_cnt_next;
                r_out_sat   <= w_sat_next;
            end else if (w_leave_out) begin
                r_out_valid <= 1'b0;
                r_out_sum   <= '0;
                r_out_cnt   <= '0;
                r_out_sat   <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_sum_o   = r_out_sum;
    assign out_cnt_o   = r_out_cnt;
    assign out_sat_o   = r_out_sat;

endmodule
